// File: rtl/sin_lut_sequencer.sv
// Phase-accumulator sequencer for the sine LUT: addresses the synchronous-read table and
// frames returned samples into lines/frames with hsync/vsync, start/stop and programmable frequency.
module sin_lut_sequencer #(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 12,
    parameter int PHASE_W = 16,
    parameter int SAMPLES = 16,
    parameter int LINES   = 4,
    parameter int H_BLANK = 2,
    parameter int V_BLANK = 4
) (
    input  logic               clkin,
    input  logic               rstn,
    input  logic               start,
    input  logic               stop,
    input  logic [PHASE_W-1:0] freq_word,
    input  logic               freq_load,
    output logic [ADDR_W-1:0]  lut_addr,
    input  logic [DATA_W-1:0]  lut_data,
    output logic [DATA_W-1:0]  sample,
    output logic               sample_valid,
    output logic               hsync,
    output logic               vsync,
    output logic               busy,
    output logic               frame_done
);

    localparam int SW        = $clog2(SAMPLES + 1);
    localparam int LW        = $clog2(LINES + 1);
    localparam int BLANK_MAX = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
    localparam int BW        = $clog2(BLANK_MAX + 1);

    localparam logic [SW-1:0] SAMP_LAST  = SW'(SAMPLES - 1);
    localparam logic [LW-1:0] LINE_LAST  = LW'(LINES - 1);
    localparam logic [BW-1:0] HB_LAST    = BW'(H_BLANK - 1);
    localparam logic [BW-1:0] VB_LAST    = BW'(V_BLANK - 1);
    localparam logic [BW-1:0] VB_PRELAST = BW'(V_BLANK - 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_HBLANK,
        S_VBLANK
    } state_t;

    state_t             state_reg;
    logic [PHASE_W-1:0] phase_reg;
    logic [PHASE_W-1:0] freq_shadow_reg;
    logic [PHASE_W-1:0] freq_active_reg;
    logic               stop_pend_reg;
    logic [SW-1:0]      samp_cnt_reg;
    logic [LW-1:0]      line_cnt_reg;
    logic [BW-1:0]      blank_cnt_reg;

    logic               p1_valid_reg;
    logic               p1_vsync_reg;

    logic [PHASE_W-1:0] freq_next;
    logic               raw_active;
    logic               raw_vsync;

    // A load coinciding with a frame boundary must take effect immediately.
    assign freq_next  = freq_load ? freq_word : freq_shadow_reg;
    assign lut_addr   = phase_reg[PHASE_W-1 -: ADDR_W];
    assign raw_active = (state_reg == S_ACTIVE);
    assign raw_vsync  = !((state_reg == S_ACTIVE) ||
                          ((state_reg == S_HBLANK) && (line_cnt_reg != LINE_LAST)));

    always_ff @(negedge clkin or negedge rstn) begin
        if (!rstn) begin
            state_reg       <= S_IDLE;
            phase_reg       <= '0;
            freq_shadow_reg <= '0;
            freq_active_reg <= '0;
            stop_pend_reg   <= 1'b0;
            samp_cnt_reg    <= '0;
            line_cnt_reg    <= '0;
            blank_cnt_reg   <= '0;
            busy            <= 1'b0;
            frame_done      <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (freq_load) begin
                freq_shadow_reg <= freq_word;
            end
            if (stop && (state_reg != S_IDLE)) begin
                stop_pend_reg <= 1'b1;
            end
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        state_reg       <= S_ACTIVE;
                        busy            <= 1'b1;
                        phase_reg       <= '0;
                        freq_active_reg <= freq_next;
                        samp_cnt_reg    <= '0;
                        line_cnt_reg    <= '0;
                        stop_pend_reg   <= 1'b0;
                    end
                end
                S_ACTIVE: begin
                    phase_reg <= phase_reg + freq_active_reg;
                    if (samp_cnt_reg == SAMP_LAST) begin
                        samp_cnt_reg  <= '0;
                        blank_cnt_reg <= '0;
                        state_reg     <= S_HBLANK;
                    end else begin
                        samp_cnt_reg <= samp_cnt_reg + SW'(1);
                    end
                end
                S_HBLANK: begin
                    if (blank_cnt_reg == HB_LAST) begin
                        blank_cnt_reg <= '0;
                        if (line_cnt_reg == LINE_LAST) begin
                            state_reg <= S_VBLANK;
                        end else begin
                            line_cnt_reg <= line_cnt_reg + LW'(1);
                            state_reg    <= S_ACTIVE;
                        end
                    end else begin
                        blank_cnt_reg <= blank_cnt_reg + BW'(1);
                    end
                end
                S_VBLANK: begin
                    if (blank_cnt_reg == VB_LAST) begin
                        blank_cnt_reg <= '0;
                        // A stop arriving in the final cycle still ends this frame.
                        if (stop_pend_reg || stop) begin
                            state_reg     <= S_IDLE;
                            busy          <= 1'b0;
                            stop_pend_reg <= 1'b0;
                        end else begin
                            state_reg       <= S_ACTIVE;
                            phase_reg       <= '0;
                            freq_active_reg <= freq_next;
                            samp_cnt_reg    <= '0;
                            line_cnt_reg    <= '0;
                        end
                    end else begin
                        blank_cnt_reg <= blank_cnt_reg + BW'(1);
                        if (blank_cnt_reg == VB_PRELAST) begin
                            frame_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    // Framing travels through two stages so it lines up with the LUT read latency.
    always_ff @(negedge clkin or negedge rstn) begin
        if (!rstn) begin
            p1_valid_reg <= 1'b0;
            p1_vsync_reg <= 1'b1;
            sample_valid <= 1'b0;
            hsync        <= 1'b0;
            vsync        <= 1'b1;
            sample       <= '0;
        end else begin
            p1_valid_reg <= raw_active;
            p1_vsync_reg <= raw_vsync;
            sample_valid <= p1_valid_reg;
            hsync        <= p1_valid_reg;
            vsync        <= p1_vsync_reg;
            if (p1_valid_reg) begin
                sample <= lut_data;
            end
        end
    end

endmodule

// File: tb/tb_sin_lut_sequencer.sv
// Bench for sin_lut_sequencer: frame-position reference model plus directed and random stimulus.
module tb_sin_lut_sequencer;

    localparam int S        = 16;
    localparam int L        = 4;
    localparam int H        = 2;
    localparam int V        = 4;
    localparam int LINE_LEN = S + H;
    localparam int FRAME    = L * LINE_LEN + V;

    logic        clkin = 1'b0;
    logic        rstn;
    logic        start;
    logic        stop;
    logic [15:0] freq_word;
    logic        freq_load;
    logic [3:0]  lut_addr;
    logic [11:0] lut_data = 12'd0;
    logic [11:0] sample;
    logic        sample_valid;
    logic        hsync;
    logic        vsync;
    logic        busy;
    logic        frame_done;

    logic [11:0] rom [16];

    int errors = 0;
    int checks = 0;

    // Reference model state: frame position, frequencies and a 2-deep output delay line.
    bit          m_run;
    int          m_pos;
    bit          m_stop_pend;
    logic [15:0] m_fact;
    logic [15:0] m_fshadow;
    bit          d1_v, d2_v, d1_vs, d2_vs;
    logic [3:0]  d1_a, d2_a;
    logic [11:0] m_sample;

    sin_lut_sequencer dut (
        .clkin        (clkin),
        .rstn         (rstn),
        .start        (start),
        .stop         (stop),
        .freq_word    (freq_word),
        .freq_load    (freq_load),
        .lut_addr     (lut_addr),
        .lut_data     (lut_data),
        .sample       (sample),
        .sample_valid (sample_valid),
        .hsync        (hsync),
        .vsync        (vsync),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    always #5 clkin = ~clkin;

    always @(negedge clkin) lut_data <= rom[lut_addr];

    function automatic bit is_active(int pos);
        return (pos < L * LINE_LEN) && ((pos % LINE_LEN) < S);
    endfunction

    function automatic int nact(int pos);
        int off;
        if (pos >= L * LINE_LEN) return L * S;
        off = pos % LINE_LEN;
        return (pos / LINE_LEN) * S + ((off < S) ? off : S);
    endfunction

    function automatic logic [3:0] exp_addr();
        logic [31:0] p;
        p = {16'd0, m_fact} * 32'(nact(m_pos));
        return p[15:12];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_pos = 0; m_stop_pend = 0;
        m_fact = 16'd0; m_fshadow = 16'd0;
        d1_v = 0; d2_v = 0; d1_vs = 1; d2_vs = 1; d1_a = 4'd0; d2_a = 4'd0;
        m_sample = 12'd0;
    endtask

    task automatic compare_all();
        check("busy", 32'(busy), 32'(m_run));
        check("frame_done", 32'(frame_done), 32'(m_run && (m_pos == FRAME - 1)));
        check("sample_valid", 32'(sample_valid), 32'(d2_v));
        check("hsync", 32'(hsync), 32'(d2_v));
        check("vsync", 32'(vsync), 32'(d2_vs));
        check("sample", 32'(sample), 32'(m_sample));
        if (m_run && is_active(m_pos)) check("lut_addr", 32'(lut_addr), 32'(exp_addr()));
    endtask

    task automatic model_advance();
        bit          rv, rvs;
        logic [3:0]  ra;
        logic [15:0] fnext;
        if (!rstn) begin
            model_reset();
            return;
        end
        rv  = m_run && is_active(m_pos);
        rvs = !(m_run && (m_pos < L * LINE_LEN - H));
        ra  = exp_addr();
        d2_v = d1_v; d2_vs = d1_vs; d2_a = d1_a;
        d1_v = rv;   d1_vs = rvs;   d1_a = ra;
        if (d2_v) m_sample = rom[d2_a];
        fnext = freq_load ? freq_word : m_fshadow;
        if (m_run) begin
            if (m_pos == FRAME - 1) begin
                if (m_stop_pend || stop) begin
                    m_run = 0; m_stop_pend = 0; m_pos = 0;
                end else begin
                    m_pos = 0; m_fact = fnext;
                end
            end else begin
                m_pos++;
                if (stop) m_stop_pend = 1;
            end
        end else if (start) begin
            m_run = 1; m_pos = 0; m_fact = fnext; m_stop_pend = 0;
        end
        if (freq_load) m_fshadow = freq_word;
    endtask

    // One clock: compare at posedge+1, drive the inputs for the coming negedge, advance the model.
    task automatic cycle(input bit s, input bit p, input bit fl, input logic [15:0] fw);
        @(posedge clkin);
        #1;
        compare_all();
        start = s; stop = p; freq_load = fl; freq_word = fw;
        model_advance();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_lut_addr"}, 32'(lut_addr), 32'd0);
        check({tag, "_sample"}, 32'(sample), 32'd0);
        check({tag, "_sample_valid"}, 32'(sample_valid), 32'd0);
        check({tag, "_hsync"}, 32'(hsync), 32'd0);
        check({tag, "_vsync"}, 32'(vsync), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    endtask

    initial begin
        int nvalid, fd_idx, nfd;
        logic [15:0] fw;

        rom[0]  = 12'd2048; rom[1]  = 12'd2831; rom[2]  = 12'd3495; rom[3]  = 12'd3939;
        rom[4]  = 12'd4095; rom[5]  = 12'd3939; rom[6]  = 12'd3495; rom[7]  = 12'd2831;
        rom[8]  = 12'd2048; rom[9]  = 12'd1265; rom[10] = 12'd601;  rom[11] = 12'd157;
        rom[12] = 12'd1;    rom[13] = 12'd157;  rom[14] = 12'd601;  rom[15] = 12'd1265;

        rstn = 1'b1; start = 0; stop = 0; freq_load = 0; freq_word = 16'd0;
        model_reset();
        #2 rstn = 1'b0;
        #1 check_reset_values("por");
        cycle(0, 0, 0, 16'h0);
        cycle(0, 0, 0, 16'h0);
        rstn = 1'b1;

        // Test 1/2: 0x1000 ramps 0..15 per line; stop during line 2 still completes the frame.
        cycle(0, 0, 1, 16'h1000);
        cycle(1, 0, 0, 16'h0);
        nvalid = 0; fd_idx = -1;
        for (int i = 0; i <= FRAME + 1; i++) begin
            cycle(0, i == 40, 0, 16'h0);
            if (sample_valid) nvalid++;
            if (frame_done) fd_idx = i;
            if (i < S) check("t1_addr", 32'(lut_addr), 32'(i));
            if (i == 1) check("t1_valid_early", 32'(sample_valid), 32'd0);
            if (i == 2) begin
                check("t1_first_valid", 32'(sample_valid), 32'd1);
                check("t1_first_sample", 32'(sample), 32'd2048);
                check("t1_first_hsync", 32'(hsync), 32'd1);
                check("t1_first_vsync", 32'(vsync), 32'd0);
            end
            if (i == S + 2) check("t1_hsync_end", 32'(hsync), 32'd0);
            if (i == FRAME) check("t2_busy_fall", 32'(busy), 32'd0);
            if (i == FRAME + 1) begin
                check("t2_idle_vsync", 32'(vsync), 32'd1);
                check("t2_idle_hsync", 32'(hsync), 32'd0);
            end
        end
        check("t2_samples", 32'(nvalid), 32'd64);
        check("t2_frame_done_idx", 32'(fd_idx), 32'(FRAME - 1));

        // Test 3/6: descending wrap, continuous phase, deferred reload, three back-to-back frames.
        cycle(0, 0, 1, 16'hF000);
        cycle(1, 0, 0, 16'h0);
        nfd = 0;
        for (int i = 0; i <= 3 * FRAME; i++) begin
            cycle(0, i == 2 * FRAME + 10, i == 30, (i == 30) ? 16'h2000 : 16'h0);
            if (i == 1) check("t3_wrap_addr", 32'(lut_addr), 32'd15);
            if (i == LINE_LEN) check("t3_line1_addr0", 32'(lut_addr), 32'd0);
            if (i == LINE_LEN + 2) check("t3_line1_addr2", 32'(lut_addr), 32'd14);
            if (i == 37) check("t3_old_freq_kept", 32'(lut_addr), 32'd15);
            if (i == FRAME) check("t6_restart_addr", 32'(lut_addr), 32'd0);
            if (i == FRAME + 1) check("t3_new_freq", 32'(lut_addr), 32'd2);
            if (frame_done) begin
                check("t6_fd_pos", 32'(i), 32'(FRAME - 1 + nfd * FRAME));
                nfd++;
            end
            if (i == 3 * FRAME) check("t6_busy_end", 32'(busy), 32'd0);
        end
        check("t6_fd_count", 32'(nfd), 32'd3);

        // Test 4: start+stop together in IDLE -> stop dropped; start while busy ignored.
        cycle(1, 1, 1, 16'h1000);
        for (int i = 0; i <= 2 * FRAME; i++) begin
            cycle(i == 20, i == FRAME + 10, 0, 16'h0);
            if (i == FRAME) check("t4_repeat_busy", 32'(busy), 32'd1);
            if (i == FRAME + 1) check("t4_repeat_addr", 32'(lut_addr), 32'd1);
            if (i == 2 * FRAME) check("t4_busy_end", 32'(busy), 32'd0);
        end

        // Test 5: asynchronous reset mid-frame.
        cycle(0, 0, 1, 16'h1000);
        cycle(1, 0, 0, 16'h0);
        for (int i = 0; i <= 30; i++) cycle(0, 0, 0, 16'h0);
        #2 rstn = 1'b0;
        #1 check_reset_values("t5");
        model_reset();
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 16'h0);
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 16'h0);
        check("t5_idle_after", 32'(busy), 32'd0);

        // Random traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            fw = ($urandom_range(3) == 0) ? 16'h0 : 16'($urandom);
            cycle($urandom_range(39) == 0, $urandom_range(149) == 0,
                  $urandom_range(59) == 0, fw);
        end
        cycle(0, 0, 0, 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
